sm_stim_driver: RTL and testbench
=================================

# sm_stim_driver

Initiator for the 3-input / 2-output Moore handshake used by the sequential example block. It drives `a_i`/`b_i`/`c_i` of the peer through one full S0→S1→S2→S3→S0 cycle per `start_i` request, using the peer's registered `y1_o`/`y2_o` as acknowledges. It also enforces a programmable gap between request and arm, a per-phase timeout, and a count of completed transactions. It sits beside the peer FSM in bring-up and self-test builds.

## Interface
- `DLY_W`, default 8: width of the arm-delay value.
- `TMO`, default 16: per-phase timeout in cycles; legal range 4..255.
- `CNT_W`, default 8: width of the completed-transaction counter.
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request one transaction; sampled only in IDLE.
- `dly_i`  in  DLY_W  cycles spent in DLY; latched when `start_i` is accepted.
- `y1_i`  in  1  peer `y1_o`.
- `y2_i`  in  1  peer `y2_o`.
- `a_o`  out  1  to peer `a_i`.
- `b_o`  out  1  to peer `b_i`.
- `c_o`  out  1  to peer `c_i`.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse on successful completion.
- `err_o`  out  1  one-cycle pulse on timeout.
- `cnt_o`  out  CNT_W  completed transactions, modulo 2^CNT_W.

## Operation
- States: IDLE, REQ, DLY, ARM, REL, DONE, ERR.
- IDLE: all outputs low. `start_i`=1 latches `dly_i` into `dly_q` and moves to REQ.
- REQ: `a_o`=1. When `y1_i`=1, go to DLY if `dly_q`≠0, otherwise go straight to ARM.
- DLY: all drives low for exactly `dly_q` cycles, then go to ARM.
- ARM: `b_o`=`c_o`=1. When `y2_i`=1, go to REL.
- REL: all drives low. When `y1_i`=0, go to DONE.
- DONE: one cycle. `done_o`=1, `cnt_o` increments and wraps from all-ones to 0. Then go to IDLE.
- ERR: one cycle. `err_o`=1, all drives low, `cnt_o` unchanged. Then go to IDLE.
- Timeout:
  - Each of REQ, ARM and REL has its own wait counter, cleared on entry.
  - If the ack condition has not been seen after TMO cycles in the state, go to ERR.
  - If the ack arrives in the same cycle the timeout expires, the ack wins.
- `start_i` is ignored outside IDLE; it is not queued.
- All outputs are registered and loaded from the decode of the next state, so they change on the same edge as the state register.
- Reset (async, any time, including mid-transaction):
  - State goes to IDLE.
  - `a_o`, `b_o`, `c_o`, `busy_o`, `done_o`, `err_o` go to 0.
  - `cnt_o` goes to 0; `dly_q` and the wait counter go to 0.

## Timing
- `start_i` sampled high at edge E0: `a_o` and `busy_o` are high after E0.
- Against the peer FSM, which registers both its state and its outputs:
  - REQ lasts 3 cycles.
  - ARM lasts 3 cycles.
  - REL lasts 3 cycles.
  - DONE lasts 1 cycle.
  - Total with `dly_i`=0: 10 cycles from E0 to `busy_o` low.
  - Total with `dly_i`=N: 10+N cycles.
- `done_o` and `err_o` are never both high; each is exactly one cycle wide.
- Earliest re-start: a `start_i` sampled in the first IDLE cycle after DONE/ERR is accepted (back-to-back transactions allowed).
- Acks are used directly as synchronous inputs; the peer shares `clk`, so no synchroniser is required.

## Test plan
- Reset, then `start_i` pulse with `dly_i`=0 against the peer FSM:
  - `a_o` high for 3 cycles, then `b_o`/`c_o` high for 3 cycles.
  - `done_o` pulse 10 cycles after start; `cnt_o`=1; peer returns to S0.
- `dly_i`=5: all drives low for exactly 5 cycles between `a_o` falling and `b_o` rising; `done_o` 15 cycles after start.
- `y1_i` tied 0, TMO=16: `a_o` high for exactly 16 cycles, then one `err_o` pulse, then IDLE; `cnt_o` unchanged.
- `start_i` held high continuously for 255 transactions with CNT_W=8:
  - Back-to-back transactions, each exactly 10 cycles plus 1 IDLE cycle.
  - `cnt_o` reaches 255; one more transaction wraps it to 0.
- `rstn` asserted while in ARM:
  - `b_o`/`c_o`/`busy_o` low immediately, without waiting for a clock edge; `cnt_o`=0.
  - After release, a new start completes normally.
- `start_i` pulsed while in DLY and ARM: no effect; exactly one `done_o` per accepted start.

Source files
------------

// File: rtl/sm_stim_driver_if.sv
// Handshake bundle between the stimulus driver and its environment.
// Carries the request/delay inputs, the peer acknowledges, the peer drives and status.
interface sm_stim_driver_if #(
  parameter int DLY_W = 8,
  parameter int CNT_W = 8
);
  logic             start_i;
  logic [DLY_W-1:0] dly_i;
  logic             y1_i;
  logic             y2_i;
  logic             a_o;
  logic             b_o;
  logic             c_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    input  start_i, dly_i, y1_i, y2_i,
    output a_o, b_o, c_o, busy_o, done_o, err_o, cnt_o
  );

  modport slave (
    output start_i, dly_i, y1_i, y2_i,
    input  a_o, b_o, c_o, busy_o, done_o, err_o, cnt_o
  );
endinterface

// File: rtl/sm_stim_driver.sv
// Initiator for the 3-in/2-out Moore handshake: one S0..S3 cycle per accepted start.
// Outputs are registered from the next-state decode; start_i is ignored while busy.
module sm_stim_driver #(
  parameter int DLY_W = 8,
  parameter int TMO   = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  sm_stim_driver_if.master   bus
);

  // One wait counter serves the timed phases and the arm delay, so it must hold both.
  localparam int WC_W = (DLY_W > 8) ? DLY_W : 8;
  localparam logic [WC_W-1:0] TMO_LAST = WC_W'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DLY  = 3'd2,
    ARM  = 3'd3,
    REL  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } st_t;

  st_t              st, nxt;
  logic [WC_W-1:0]  wcnt, wcnt_nxt;
  logic [WC_W-1:0]  dly_last;
  logic [DLY_W-1:0] dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q, b_q, c_q, busy_q, done_q, err_q;

  assign dly_last = WC_W'(dly_q) - WC_W'(1);

  always_comb begin
    nxt      = st;
    wcnt_nxt = wcnt + WC_W'(1);
    case (st)
      IDLE: begin
        if (bus.start_i) nxt = REQ;
      end
      REQ: begin
        // An ack that lands on the expiry cycle still counts as success.
        if (bus.y1_i)            nxt = (dly_q != '0) ? DLY : ARM;
        else if (wcnt == TMO_LAST) nxt = ERR;
      end
      DLY: begin
        if (wcnt == dly_last) nxt = ARM;
      end
      ARM: begin
        if (bus.y2_i)            nxt = REL;
        else if (wcnt == TMO_LAST) nxt = ERR;
      end
      REL: begin
        if (!bus.y1_i)           nxt = DONE;
        else if (wcnt == TMO_LAST) nxt = ERR;
      end
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (nxt != st || st == IDLE) wcnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st     <= IDLE;
      wcnt   <= '0;
      dly_q  <= '0;
      cnt_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      c_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st     <= nxt;
      wcnt   <= wcnt_nxt;
      if (st == IDLE && bus.start_i) dly_q <= bus.dly_i;
      if (nxt == DONE) cnt_q <= cnt_q + CNT_W'(1);
      a_q    <= (nxt == REQ);
      b_q    <= (nxt == ARM);
      c_q    <= (nxt == ARM);
      busy_q <= (nxt != IDLE);
      done_q <= (nxt == DONE);
      err_q  <= (nxt == ERR);
    end
  end

  assign bus.a_o    = a_q;
  assign bus.b_o    = b_q;
  assign bus.c_o    = c_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;
  assign bus.cnt_o  = cnt_q;

endmodule

// File: tb/tb_sm_stim_driver.sv
// Bench for sm_stim_driver against a behavioural peer with selectable stall points.
module tb_sm_stim_driver;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sm_stim_driver_if #(.DLY_W(8), .CNT_W(8)) bus ();

  sm_stim_driver #(.DLY_W(8), .TMO(TMO), .CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Peer: registered state, outputs registered from the current state (one cycle behind).
  // hold=k freezes the peer in state k-1 so the driver's phase k never sees its ack.
  logic [1:0] pst;
  logic       py1, py2;
  logic       peer_clr = 1'b0;
  int         hold = 0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pst <= 2'd0; py1 <= 1'b0; py2 <= 1'b0;
    end else if (peer_clr) begin
      pst <= 2'd0; py1 <= 1'b0; py2 <= 1'b0;
    end else begin
      py1 <= (pst == 2'd1) || (pst == 2'd2);
      py2 <= (pst == 2'd2);
      case (pst)
        2'd0: if (bus.a_o && hold != 1) pst <= 2'd1;
        2'd1: if (bus.b_o && bus.c_o && hold != 2) pst <= 2'd2;
        2'd2: if (!bus.a_o && !bus.b_o && !bus.c_o && hold != 3) pst <= 2'd3;
        default: pst <= 2'd0;
      endcase
    end
  end

  assign bus.y1_i = py1;
  assign bus.y2_i = py2;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic peer_clear();
    @(negedge clk); peer_clr = 1'b1;
    @(negedge clk); peer_clr = 1'b0;
    hold = 0;
  endtask

  // Runs one transaction from a negedge in IDLE; mode selects the peer stall point.
  task automatic run_txn(input int n, input int mode, input bit stray);
    int busy_c = 0, a_c = 0, gap_c = 0, bc_c = 0, done_c = 0, err_c = 0;
    int done_idx = -1, cnt_at_done = -1, cyc = 0, both = 0;
    int e_busy, e_a, e_gap, e_bc;
    bit seen_a = 0, seen_bc = 0;
    hold = mode;
    bus.dly_i = 8'(n);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (bus.busy_o && cyc < 400) begin
      busy_c++;
      if (bus.a_o) begin a_c++; seen_a = 1; end
      if (bus.b_o && bus.c_o) begin bc_c++; seen_bc = 1; end
      if (seen_a && !seen_bc && !bus.a_o && !bus.b_o && !bus.c_o && !bus.done_o && !bus.err_o)
        gap_c++;
      if (bus.done_o) begin done_c++; done_idx = cyc; cnt_at_done = int'(bus.cnt_o); end
      if (bus.err_o) err_c++;
      if (bus.done_o && bus.err_o) both++;
      bus.start_i = stray && ($urandom_range(0, 2) == 0);
      cyc++;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    case (mode)
      0: begin e_busy = 10 + n;             e_a = 3;   e_gap = n; e_bc = 3;   end
      1: begin e_busy = TMO + 1;            e_a = TMO; e_gap = 0; e_bc = 0;   end
      2: begin e_busy = 3 + n + TMO + 1;    e_a = 3;   e_gap = n; e_bc = TMO; end
      default: begin e_busy = 3 + n + 3 + TMO + 1; e_a = 3; e_gap = n; e_bc = 3; end
    endcase
    chk("busy_len", busy_c, e_busy);
    chk("a_len", a_c, e_a);
    chk("gap_len", gap_c, e_gap);
    chk("bc_len", bc_c, e_bc);
    chk("done_cnt", done_c, (mode == 0) ? 1 : 0);
    chk("err_cnt", err_c, (mode == 0) ? 0 : 1);
    chk("done_err_both", both, 0);
    if (mode == 0) begin
      exp_cnt = (exp_cnt + 1) % 256;
      chk("done_idx", done_idx, 9 + n);
      chk("cnt_at_done", cnt_at_done, exp_cnt);
    end
    chk("cnt_after", int'(bus.cnt_o), exp_cnt);
    if (mode != 0) peer_clear();
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    int k, last, cyc, seen;
    bus.start_i = 1'b0;
    bus.dly_i   = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_a", int'(bus.a_o), 0);
    chk("rst_b", int'(bus.b_o), 0);
    chk("rst_c", int'(bus.c_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_err", int'(bus.err_o), 0);
    chk("rst_cnt", int'(bus.cnt_o), 0);
    rstn = 1'b1;
    @(negedge clk);

    run_txn(0, 0, 0);
    chk("peer_s0", int'(pst), 0);
    run_txn(5, 0, 0);
    run_txn(0, 1, 0);
    run_txn(3, 0, 1);
    run_txn(2, 2, 0);
    run_txn(1, 3, 0);

    for (int i = 0; i < 40; i++) begin
      int n, mode;
      n = $urandom_range(0, 12);
      mode = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(n, mode, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Async reset while ARM is driving b/c.
    bus.dly_i = 8'd0;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    cyc = 0;
    while (!bus.b_o && cyc < 20) begin cyc++; @(negedge clk); end
    chk("arm_reached", int'(bus.b_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_b", int'(bus.b_o), 0);
    chk("arst_c", int'(bus.c_o), 0);
    chk("arst_busy", int'(bus.busy_o), 0);
    chk("arst_cnt", int'(bus.cnt_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    run_txn(4, 0, 0);

    // Start held high: back-to-back transactions through the counter wrap.
    do_reset();
    hold = 0;
    bus.dly_i = 8'd0;
    bus.start_i = 1'b1;
    k = 0; last = -1; cyc = 0; seen = 0;
    while (k < 256 && cyc < 256 * 11 + 50) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o) begin
        k++;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("b2b_cnt", int'(bus.cnt_o), exp_cnt);
        if (last >= 0) chk("b2b_period", cyc - last, 11);
        last = cyc;
        if (k == 255) chk("cnt_255", int'(bus.cnt_o), 255);
        if (k == 256) begin chk("cnt_wrap", int'(bus.cnt_o), 0); bus.start_i = 1'b0; end
      end
    end
    bus.start_i = 1'b0;
    chk("b2b_count", k, 256);
    repeat (3) @(negedge clk);
    chk("b2b_idle", int'(bus.busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
